// File: rtl/status_reg.sv
// -----------------------------------------------------------------------------
// status_reg
//   Processor status (P) register that sits directly downstream of the ALU.
//
//   When an ALU op is issued (aluLatch), the operand signs and the flag-update
//   enables are captured into a one-deep pending stage. On the following edge
//   the ALU's registered result (res) and carry-out (cin) are valid. N/Z/C/V
//   are then derived from them. Back-to-back ops pipeline fully: stage 2
//   retires op k while stage 1 captures op k+1.
//
//   The register also handles the following operations:
//     - PLP/RTI loads from the data bus (dbLoad).
//     - N/Z updates straight from the data bus for load instructions (nzDb).
//     - Explicit SEC/CLC/SEI/CLI/SED/CLD/CLV controls.
//     - PHP/BRK pushes onto the data bus (dbOe, brkPush).
//
//   Per-flag priority at an edge, highest first:
//     dbLoad > set/clr (clr beats set) > nzDb > stage-2 ALU update > hold
//
// Parameters
//   RST_P    P value after reset. Bits 5 and 4 are fixed by the P layout and
//            are not taken from RST_P.
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous, active-high reset
//   aluLatch            ALU op issued this cycle
//   aSign, bSign        bit 7 of the ALU operands for the issued op
//   opSub               issued op is a subtract (ALU cout is then a borrow)
//   updNZ, updC, updV   issued op updates N/Z, C, V
//   res, cin            ALU result and carry-out, valid the cycle after aluLatch
//   nzDb                update N,Z from dbIn
//   dbLoad              load P from dbIn (bits 5:4 ignored)
//   dbIn                data bus in
//   setC..clrV          explicit flag set/clear controls
//   brkPush             value presented on bit 4 of dbOut
//   dbOe                drive P onto dbOut, otherwise dbOut is released (z)
//   dbOut               {N,V,1,brkPush,D,I,Z,C} or 8'hzz
//   pOut                {N,V,1,0,D,I,Z,C}, always driven
//   carry               C flag, to the ALU carry-in
//   decEn               D flag, to the ALU decimal enable
// -----------------------------------------------------------------------------
module status_reg #(
    parameter logic [7:0] RST_P = 8'h24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       aluLatch,
    input  logic       aSign,
    input  logic       bSign,
    input  logic       opSub,
    input  logic       updNZ,
    input  logic       updC,
    input  logic       updV,
    input  logic [7:0] res,
    input  logic       cin,
    input  logic       nzDb,
    input  logic       dbLoad,
    input  logic [7:0] dbIn,
    input  logic       setC,
    input  logic       clrC,
    input  logic       setI,
    input  logic       clrI,
    input  logic       setD,
    input  logic       clrD,
    input  logic       clrV,
    input  logic       brkPush,
    input  logic       dbOe,
    output logic [7:0] dbOut,
    output logic [7:0] pOut,
    output logic       carry,
    output logic       decEn
);

    // Everything stage 2 needs to know about the op captured in stage 1.
    typedef struct packed {
        logic a_sign;
        logic b_sign;
        logic sub;
        logic upd_nz;
        logic upd_c;
        logic upd_v;
    } alu_op_t;

    logic    pend;
    alu_op_t op_q;

    logic flag_n, flag_v, flag_d, flag_i, flag_z, flag_c;
    logic n_nxt, v_nxt, d_nxt, i_nxt, z_nxt, c_nxt;

    logic alu_nz_en, alu_c_en, alu_v_en;
    logic alu_z, alu_c, alu_v;

    // Stage-2 flag values derived from the ALU's registered result.
    always_comb begin
        alu_nz_en = pend & op_q.upd_nz;
        alu_c_en  = pend & op_q.upd_c;
        alu_v_en  = pend & op_q.upd_v;
        alu_z     = (res == 8'h00);
        // On a subtract the ALU's carry-out is a borrow, so C is its inverse.
        alu_c     = op_q.sub ? ~cin : cin;
        // Overflow: the result sign differs from A. For an add, A and B must
        // have equal signs. For a subtract, A and B must have opposite signs.
        alu_v     = (res[7] != op_q.a_sign) &
                    (op_q.sub ? (op_q.a_sign != op_q.b_sign)
                              : (op_q.a_sign == op_q.b_sign));
    end

    // Per-flag next-state, each an explicit priority chain.
    always_comb begin
        // NOTE: every next-state signal takes a value on every path (the final
        // else holds), so this block describes pure logic and infers no latch.
        if (dbLoad)         n_nxt = dbIn[7];
        else if (nzDb)      n_nxt = dbIn[7];
        else if (alu_nz_en) n_nxt = res[7];
        else                n_nxt = flag_n;

        if (dbLoad)         z_nxt = dbIn[1];
        else if (nzDb)      z_nxt = (dbIn == 8'h00);
        else if (alu_nz_en) z_nxt = alu_z;
        else                z_nxt = flag_z;

        if (dbLoad)         c_nxt = dbIn[0];
        else if (clrC)      c_nxt = 1'b0;
        else if (setC)      c_nxt = 1'b1;
        else if (alu_c_en)  c_nxt = alu_c;
        else                c_nxt = flag_c;

        if (dbLoad)         v_nxt = dbIn[6];
        else if (clrV)      v_nxt = 1'b0;
        else if (alu_v_en)  v_nxt = alu_v;
        else                v_nxt = flag_v;

        if (dbLoad)         i_nxt = dbIn[2];
        else if (clrI)      i_nxt = 1'b0;
        else if (setI)      i_nxt = 1'b1;
        else                i_nxt = flag_i;

        if (dbLoad)         d_nxt = dbIn[3];
        else if (clrD)      d_nxt = 1'b0;
        else if (setD)      d_nxt = 1'b1;
        else                d_nxt = flag_d;
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values and the two pipeline stages overlap correctly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // The pending op is dropped, so the first edge after reset
            // cannot apply a stale ALU result.
            pend   <= 1'b0;
            op_q   <= '0;
            flag_n <= RST_P[7];
            flag_v <= RST_P[6];
            flag_d <= RST_P[3];
            flag_i <= RST_P[2];
            flag_z <= RST_P[1];
            flag_c <= RST_P[0];
        end else begin
            pend <= aluLatch;
            if (aluLatch) begin
                op_q <= '{a_sign: aSign, b_sign: bSign, sub: opSub,
                          upd_nz: updNZ, upd_c: updC, upd_v: updV};
            end
            flag_n <= n_nxt;
            flag_v <= v_nxt;
            flag_d <= d_nxt;
            flag_i <= i_nxt;
            flag_z <= z_nxt;
            flag_c <= c_nxt;
        end
    end

    assign pOut  = {flag_n, flag_v, 1'b1, 1'b0, flag_d, flag_i, flag_z, flag_c};
    assign dbOut = dbOe ? {flag_n, flag_v, 1'b1, brkPush, flag_d, flag_i, flag_z, flag_c}
                        : 8'hzz;
    assign carry = flag_c;
    assign decEn = flag_d;

endmodule
